load_store_unit: RTL and testbench

- Initiator side of the core's data-memory interface.
- Accepts one load/store request at a time from the execute stage, decoded by RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Drives the word-only, strobe-triggered data memory (Mem_Read/Mem_Write pulses, Address, Write_Data, Read_Data).
- Byte and halfword stores are done as read-modify-write. Load data is extracted, sign/zero-extended and returned to writeback.

---
 rtl/load_store_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-only, strobe-triggered data memory; sub-word stores use read-modify-write.
// Optional single-entry word cache enabled by defining LSU_WCACHE_EN (lets cached SB/SH skip the read phase).
module load_store_unit #(
  parameter int MEM_WAIT  = 1,
  parameter int IDX_WIDTH = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [31:0] Address,
  output logic [31:0] Write_Data,
  input  logic [31:0] Read_Data
);

  typedef enum logic [2:0] {IDLE, RD_STB, RD_WAIT, MERGE, WR_STB, RESP} state_t;

  state_t      state_reg, state_next;
  logic        req_ready_reg, req_ready_next;
  logic        resp_valid_reg, resp_valid_next;
  logic        resp_err_reg, resp_err_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] write_data_reg, write_data_next;
  logic        store_reg, store_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [1:0]  off_reg, off_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic        cache_hit;

`ifdef LSU_WCACHE_EN
  logic                 cache_valid_reg, cache_valid_next;
  logic [IDX_WIDTH-1:0] cache_idx_reg, cache_idx_next;
  logic [31:0]          cache_data_reg, cache_data_next;
`endif

  function automatic logic legal_op(input logic store, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    if (store) ok = (f3 <= 3'd2);
    else       ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    // funct3[1:0] encodes access size for every legal code
    case (f3[1:0])
      2'd1:    if (off[0])       ok = 1'b0;
      2'd2:    if (off != 2'd0)  ok = 1'b0;
      default: ;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'b0, b};
      3'd5:    r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                        input logic [2:0] f3, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'd0) r[{off, 3'b000} +: 8]     = wd[7:0];
    else            r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

`ifdef LSU_WCACHE_EN
  assign cache_hit = cache_valid_reg && (cache_idx_reg == req_addr[IDX_WIDTH+1:2]);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    req_ready_next  = 1'b0;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    address_next    = address_reg;
    write_data_next = write_data_reg;
    store_next      = store_reg;
    funct3_next     = funct3_reg;
    off_next        = off_reg;
    wdata_next      = wdata_reg;
    wait_cnt_next   = wait_cnt_reg;
`ifdef LSU_WCACHE_EN
    cache_valid_next = cache_valid_reg;
    cache_idx_next   = cache_idx_reg;
    cache_data_next  = cache_data_reg;
`endif
    case (state_reg)
      IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid) begin
          req_ready_next = 1'b0;
          store_next     = req_store;
          funct3_next    = req_funct3;
          off_next       = req_addr[1:0];
          wdata_next     = req_wdata[15:0];
          address_next   = 32'(req_addr[IDX_WIDTH+1:2]);
          if (!legal_op(req_store, req_funct3, req_addr[1:0])) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'h0;
          end else if (req_store && req_funct3 == 3'd2) begin
            write_data_next = req_wdata;
            mem_write_next  = 1'b1;
            state_next      = WR_STB;
          end else if (req_store && cache_hit) begin
`ifdef LSU_WCACHE_EN
            write_data_next = merge(cache_data_reg, req_addr[1:0], req_funct3, req_wdata[15:0]);
`endif
            state_next = MERGE;
          end else begin
            mem_read_next = 1'b1;
            state_next    = RD_STB;
          end
        end
      end
      RD_STB: begin
        wait_cnt_next = 3'(MEM_WAIT - 1);
        state_next    = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt_reg == 3'd0) begin
`ifdef LSU_WCACHE_EN
          cache_valid_next = 1'b1;
          cache_idx_next   = address_reg[IDX_WIDTH-1:0];
          cache_data_next  = Read_Data;
`endif
          // merged word is ready a full cycle before the write strobe rises
          if (store_reg) begin
            write_data_next = merge(Read_Data, off_reg, funct3_reg, wdata_reg);
            state_next      = MERGE;
          end else begin
            resp_rdata_next = extract(Read_Data, off_reg, funct3_reg);
            resp_valid_next = 1'b1;
            state_next      = RESP;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      MERGE: begin
        mem_write_next = 1'b1;
        state_next     = WR_STB;
      end
      WR_STB: begin
`ifdef LSU_WCACHE_EN
        cache_valid_next = 1'b1;
        cache_idx_next   = address_reg[IDX_WIDTH-1:0];
        cache_data_next  = write_data_reg;
`endif
        resp_valid_next = 1'b1;
        resp_rdata_next = 32'h0;
        state_next      = RESP;
      end
      RESP: begin
        req_ready_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      address_reg    <= 32'h0;
      write_data_reg <= 32'h0;
      store_reg      <= 1'b0;
      funct3_reg     <= 3'd0;
      off_reg        <= 2'd0;
      wdata_reg      <= 16'h0;
      wait_cnt_reg   <= 3'd0;
`ifdef LSU_WCACHE_EN
      cache_valid_reg <= 1'b0;
      cache_idx_reg   <= '0;
      cache_data_reg  <= 32'h0;
`endif
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      address_reg    <= address_next;
      write_data_reg <= write_data_next;
      store_reg      <= store_next;
      funct3_reg     <= funct3_next;
      off_reg        <= off_next;
      wdata_reg      <= wdata_next;
      wait_cnt_reg   <= wait_cnt_next;
`ifdef LSU_WCACHE_EN
      cache_valid_reg <= cache_valid_next;
      cache_idx_reg   <= cache_idx_next;
      cache_data_reg  <= cache_data_next;
`endif
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign Mem_Read   = mem_read_reg;
  assign Mem_Write  = mem_write_reg;
  assign Address    = address_reg;
  assign Write_Data = write_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps plus random ops against a byte-level memory model.
// The word-cache expectations follow LSU_WCACHE_EN when it is defined for the build.
module tb_load_store_unit;

  localparam int MW = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data = 32'h0;

  load_store_unit #(.MEM_WAIT(MW), .IDX_WIDTH(30)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Address(Address),
    .Write_Data(Write_Data), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  // Memory device seen by the DUT
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (Mem_Write) mem[Address[3:0]] <= Write_Data;
    if (Mem_Read)  Read_Data <= mem[Address[3:0]];
  end

  int rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, resp_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;
  always @(posedge clk) begin
    if (Mem_Read) rd_cnt++;
    if (Mem_Write) begin
      wr_cnt++;
      last_wr_addr = Address;
      last_wr_data = Write_Data;
    end
    if (Mem_Read && Mem_Write) overlap_cnt++;
    if (resp_valid) resp_cnt++;
  end

  int checks = 0, errors = 0;
  logic [31:0] ref_mem [16];
  int cache_idx = -1;
  int op_lat, op_reads;
  logic [31:0] op_rdata;
  logic op_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (st && f3 > 3'd2) return 1'b1;
    if (!st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    w = ref_mem[a[5:2]];
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'd2:    v = w;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask, sh;
    if (f3 == 3'd2) begin
      ref_mem[a[5:2]] = wd;
      return;
    end
    sh   = (f3 == 3'd0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~mask) | ((wd << sh) & mask);
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int rd0, wr0, lat, exp_lat, exp_rd, exp_wr, w;
    logic err, hit;
    logic [31:0] exp_rdata;
    w = 0;
    while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
    err = is_err(st, f3, a);
    hit = 1'b0;
`ifdef LSU_WCACHE_EN
    hit = st && f3 != 3'd2 && !err && cache_idx == int'(a[5:2]);
`endif
    exp_rdata = (err || st) ? 32'h0 : ref_load(f3, a);
    if (err) begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
    else if (!st) begin exp_lat = 2 + MW; exp_rd = 1; exp_wr = 0; end
    else if (f3 == 3'd2) begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
    else if (hit) begin exp_lat = 3; exp_rd = 0; exp_wr = 1; end
    else begin exp_lat = 4 + MW; exp_rd = 1; exp_wr = 1; end
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_drop", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("resp_seen", 32'(resp_valid), 32'd1);
    if (!err && st) ref_store(f3, a, wd);
    if (!err) cache_idx = int'(a[5:2]);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(err));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("reads", 32'(rd_cnt - rd0), 32'(exp_rd));
    check("writes", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr == 1) begin
      check("wr_addr", last_wr_addr, {28'h0, a[5:2]});
      check("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
    end
    op_lat = lat; op_reads = rd_cnt - rd0; op_rdata = resp_rdata; op_err = resp_err;
    $display("op st=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d reads=%0d",
             st, f3, a, wd, resp_rdata, resp_err, lat, rd_cnt - rd0);
  endtask

  initial begin
    logic st;
    logic [2:0] f3;
    int resp0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_read", 32'(Mem_Read), 32'd0);
    check("rst_mem_write", 32'(Mem_Write), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_address", Address, 32'h0);
    check("rst_wdata", Write_Data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) do_op(1'b1, 3'd2, 32'(i * 4), $urandom);

    do_op(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
    check("sw_lat", 32'(op_lat), 32'd2);
    check("sw_wr_addr", last_wr_addr, 32'd2);
    check("sw_wr_data", last_wr_data, 32'hDEADBEEF);

    do_op(1'b1, 3'd2, 32'h8, 32'h80F17F01);
    do_op(1'b0, 3'd0, 32'hB, 32'h0);
    check("lb", op_rdata, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'hB, 32'h0);
    check("lbu", op_rdata, 32'h00000080);
    do_op(1'b0, 3'd1, 32'hA, 32'h0);
    check("lh", op_rdata, 32'hFFFF80F1);
    do_op(1'b0, 3'd5, 32'h8, 32'h0);
    check("lhu", op_rdata, 32'h00007F01);
    check("lhu_lat", 32'(op_lat), 32'd3);

    do_op(1'b1, 3'd2, 32'h4, 32'h11223344);
    do_op(1'b1, 3'd0, 32'h5, 32'hAB);
    check("sb_wdata", last_wr_data, 32'h1122AB44);
    do_op(1'b1, 3'd1, 32'h6, 32'hCAFE);
    check("sh_wdata", last_wr_data, 32'hCAFEAB44);

    do_op(1'b0, 3'd2, 32'h6, 32'h0);
    check("lw_mis_err", 32'(op_err), 32'd1);
    do_op(1'b1, 3'd1, 32'h3, 32'h1234);
    check("sh_mis_err", 32'(op_err), 32'd1);
    do_op(1'b0, 3'd3, 32'h0, 32'h0);
    check("f3_ill_lat", 32'(op_lat), 32'd1);

    // Reset during the read phase of an SB
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h4; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    resp0 = resp_cnt;
    check("abort_mem_read", 32'(Mem_Read), 32'd0);
    check("abort_mem_write", 32'(Mem_Write), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cache_idx = -1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_resp", 32'(resp_cnt - resp0), 32'd0);
    check("abort_mem1", mem[1], ref_mem[1]);
    $display("reset abort: mem[1]=%h ready=%0d", mem[1], req_ready);

    do_op(1'b0, 3'd2, 32'h4, 32'h0);
    do_op(1'b1, 3'd0, 32'h5, 32'h77);
`ifdef LSU_WCACHE_EN
    check("cache_sb_reads", 32'(op_reads), 32'd0);
    check("cache_sb_lat", 32'(op_lat), 32'd3);
`else
    check("nocache_sb_lat", 32'(op_lat), 32'(4 + MW));
`endif

    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = (st && $urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_op(st, f3, 32'($urandom_range(0, 63)), $urandom);
    end

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
    check("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
